// File: rtl/mul_div_unit.sv
// mul_div_unit
// Iterative multiply/divide unit for the MIPS EX stage. Executes MULT,
// MULTU, DIV and DIVU into a HI/LO result pair using a shift-add
// multiplier (one multiplier bit per cycle, LSB first) and a restoring
// divider (one quotient bit per cycle, MSB first).
//
// Ports:
//   clk_i          clock, rising edge
//   rst_i          synchronous active-high reset
//   start_i        request an operation (sampled only when idle)
//   op_i           00 MULTU, 01 MULT, 10 DIVU, 11 DIV
//   data0_i        multiplicand / dividend (rs)
//   data1_i        multiplier / divisor (rt)
//   flush_i        abort the operation in flight, block a start when idle
//   busy_o         operation in flight
//   done_o         one-cycle pulse, hi_o/lo_o updated this cycle
//   hi_o           product upper half or remainder
//   lo_o           product lower half or quotient
//   div_by_zero_o  last completed divide had a zero divisor
//
// Latency: start accepted at edge E0, results and done_o at E0+WIDTH+1.

module mul_div_unit #(
  parameter int WIDTH = 32
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             start_i,
  input  logic [1:0]       op_i,
  input  logic [WIDTH-1:0] data0_i,
  input  logic [WIDTH-1:0] data1_i,
  input  logic             flush_i,
  output logic             busy_o,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             div_by_zero_o
);

  localparam int CNT_W = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   count;

  // Shared datapath register. Multiply: full 2*WIDTH accumulator with the
  // multiplier in the low half being shifted out. Divide: upper half is the
  // partial remainder, lower half holds dividend bits being shifted out
  // while quotient bits are shifted in.
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opnd;
  logic [WIDTH-1:0]   raw_dividend;
  logic               is_div;
  logic               neg_main;
  logic               neg_rem;
  logic               dbz;

  logic               is_signed;
  logic               sign0;
  logic               sign1;
  logic [WIDTH-1:0]   mag0;
  logic [WIDTH-1:0]   mag1;

  // Operand conditioning at acceptance: signed ops use magnitudes and the
  // signs are reapplied at the end. The magnitude of the most negative
  // value still fits in WIDTH unsigned bits.
  always_comb begin
    is_signed = op_i[0];
    sign0     = is_signed & data0_i[WIDTH-1];
    sign1     = is_signed & data1_i[WIDTH-1];
    mag0      = sign0 ? -data0_i : data0_i;
    mag1      = sign1 ? -data1_i : data1_i;
  end

  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic [WIDTH-1:0]   div_diff;
  logic               div_borrow;
  logic [2*WIDTH-1:0] acc_step;

  // One iteration of either algorithm. For the divider, div_shift is the
  // WIDTH+1 bit partial remainder after shifting in the next dividend bit.
  // A successful subtraction always leaves a value below the divisor, so
  // the stored remainder fits in WIDTH bits.
  always_comb begin
    mul_sum    = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opnd} : '0);
    div_shift  = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]};
    div_borrow = div_shift < {1'b0, opnd};
    div_diff   = div_shift[WIDTH-1:0] - opnd;
    if (is_div) begin
      acc_step = {(div_borrow ? div_shift[WIDTH-1:0] : div_diff),
                  acc[WIDTH-2:0], ~div_borrow};
    end else begin
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    end
  end

  logic [2*WIDTH-1:0] prod_fixed;
  logic [WIDTH-1:0]   quo_fixed;
  logic [WIDTH-1:0]   rem_fixed;

  // Sign restoration. neg_main is the product sign for multiplies and the
  // quotient sign for divides; the remainder follows the dividend sign.
  always_comb begin
    prod_fixed = neg_main ? -acc : acc;
    quo_fixed  = neg_main ? -acc[WIDTH-1:0] : acc[WIDTH-1:0];
    rem_fixed  = neg_rem ? -acc[2*WIDTH-1:WIDTH] : acc[2*WIDTH-1:WIDTH];
  end

  // Control FSM and all registered outputs. Priority is reset, then flush,
  // then start. A flush abandons the operation without touching results.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state         <= IDLE;
      count         <= '0;
      acc           <= '0;
      opnd          <= '0;
      raw_dividend  <= '0;
      is_div        <= 1'b0;
      neg_main      <= 1'b0;
      neg_rem       <= 1'b0;
      dbz           <= 1'b0;
      busy_o        <= 1'b0;
      done_o        <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      div_by_zero_o <= 1'b0;
    end else begin
      done_o <= 1'b0;
      case (state)
        IDLE: begin
          if (start_i && !flush_i) begin
            is_div       <= op_i[1];
            neg_main     <= sign0 ^ sign1;
            neg_rem      <= sign0;
            dbz          <= op_i[1] && (data1_i == '0);
            raw_dividend <= data0_i;
            if (op_i[1]) begin
              acc  <= {{WIDTH{1'b0}}, mag0};
              opnd <= mag1;
            end else begin
              acc  <= {{WIDTH{1'b0}}, mag1};
              opnd <= mag0;
            end
            count  <= CNT_W'(WIDTH);
            busy_o <= 1'b1;
            state  <= RUN;
          end
        end
        RUN: begin
          if (flush_i) begin
            count  <= '0;
            busy_o <= 1'b0;
            state  <= IDLE;
          end else begin
            acc   <= acc_step;
            count <= count - CNT_W'(1);
            if (count == CNT_W'(1)) begin
              state <= FIX;
            end
          end
        end
        FIX: begin
          busy_o <= 1'b0;
          state  <= IDLE;
          if (!flush_i) begin
            done_o        <= 1'b1;
            div_by_zero_o <= dbz;
            if (is_div) begin
              // A zero divisor reports the dividend exactly as presented.
              if (dbz) begin
                lo_o <= '1;
                hi_o <= raw_dividend;
              end else begin
                lo_o <= quo_fixed;
                hi_o <= rem_fixed;
              end
            end else begin
              lo_o <= prod_fixed[WIDTH-1:0];
              hi_o <= prod_fixed[2*WIDTH-1:WIDTH];
            end
          end
        end
        default: begin
          busy_o <= 1'b0;
          state  <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mul_div_unit.sv
// tb_mul_div_unit
// Scoreboard bench for mul_div_unit. Two instances (WIDTH=32 and WIDTH=8)
// share the clock and reset. Stimulus pushes hand-computed HI/LO/div-by-zero
// results into a per-instance queue; a monitor pops and compares whenever
// done_o is seen. Latency, busy duration, flush and reset behaviour are
// checked by the stimulus process.

module tb_mul_div_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;

  logic        start32, flush32;
  logic [1:0]  op32;
  logic [31:0] a32, b32;
  logic        busy32, done32, dbz32;
  logic [31:0] hi32, lo32;

  logic        start8, flush8;
  logic [1:0]  op8;
  logic [7:0]  a8, b8;
  logic        busy8, done8, dbz8;
  logic [7:0]  hi8, lo8;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  exp_t exp_q32[$];
  exp_t exp_q8[$];
  exp_t e32, e8;

  mul_div_unit #(.WIDTH(32)) dut32 (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start32),
    .op_i          (op32),
    .data0_i       (a32),
    .data1_i       (b32),
    .flush_i       (flush32),
    .busy_o        (busy32),
    .done_o        (done32),
    .hi_o          (hi32),
    .lo_o          (lo32),
    .div_by_zero_o (dbz32)
  );

  mul_div_unit #(.WIDTH(8)) dut8 (
    .clk_i         (clk),
    .rst_i         (rst),
    .start_i       (start8),
    .op_i          (op8),
    .data0_i       (a8),
    .data1_i       (b8),
    .flush_i       (flush8),
    .busy_o        (busy8),
    .done_o        (done8),
    .hi_o          (hi8),
    .lo_o          (lo8),
    .div_by_zero_o (dbz8)
  );

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitors: pop one expected result per done pulse.
  always @(negedge clk) begin
    if (!rst && done32) begin
      if (exp_q32.size() == 0) begin
        checkOutput("done32_unexpected", {31'b0, done32}, 32'd0);
      end else begin
        e32 = exp_q32.pop_front();
        checkOutput("hi32", hi32, e32.hi);
        checkOutput("lo32", lo32, e32.lo);
        checkOutput("dbz32", {31'b0, dbz32}, {31'b0, e32.dbz});
      end
    end
  end

  always @(negedge clk) begin
    if (!rst && done8) begin
      if (exp_q8.size() == 0) begin
        checkOutput("done8_unexpected", {31'b0, done8}, 32'd0);
      end else begin
        e8 = exp_q8.pop_front();
        checkOutput("hi8", {24'b0, hi8}, e8.hi);
        checkOutput("lo8", {24'b0, lo8}, e8.lo);
        checkOutput("dbz8", {31'b0, dbz8}, {31'b0, e8.dbz});
      end
    end
  end

  // Issue one operation, queue its expected result, and time busy/done.
  task automatic applyStimulus(input bit sel, input logic [1:0] op,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [31:0] ehi, input logic [31:0] elo,
                               input logic edbz);
    exp_t e;
    int   cycles;
    int   busy_cnt;
    int   width;
    logic d, bz;
    e.hi  = ehi;
    e.lo  = elo;
    e.dbz = edbz;
    width = sel ? 8 : 32;
    @(negedge clk);
    if (sel) begin
      start8 = 1'b1; op8 = op; a8 = a[7:0]; b8 = b[7:0];
      exp_q8.push_back(e);
    end else begin
      start32 = 1'b1; op32 = op; a32 = a; b32 = b;
      exp_q32.push_back(e);
    end
    @(negedge clk);
    start8   = 1'b0;
    start32  = 1'b0;
    cycles   = 0;
    busy_cnt = 0;
    d  = sel ? done8 : done32;
    bz = sel ? busy8 : busy32;
    while (!d && cycles < 200) begin
      if (bz) busy_cnt++;
      @(negedge clk);
      cycles++;
      d  = sel ? done8 : done32;
      bz = sel ? busy8 : busy32;
    end
    checkOutput(sel ? "latency8" : "latency32", 32'(cycles), 32'(width + 1));
    checkOutput(sel ? "busy_cycles8" : "busy_cycles32", 32'(busy_cnt), 32'(width + 1));
    checkOutput(sel ? "busy_at_done8" : "busy_at_done32", {31'b0, bz}, 32'd0);
  endtask

  initial begin
    rst = 1'b1;
    start32 = 1'b0; flush32 = 1'b0; op32 = 2'b00; a32 = '0; b32 = '0;
    start8  = 1'b0; flush8  = 1'b0; op8  = 2'b00; a8  = '0; b8  = '0;
    repeat (3) @(negedge clk);
    checkOutput("rst_busy32", {31'b0, busy32}, 32'd0);
    checkOutput("rst_done32", {31'b0, done32}, 32'd0);
    checkOutput("rst_hi32", hi32, 32'd0);
    checkOutput("rst_lo32", lo32, 32'd0);
    checkOutput("rst_dbz32", {31'b0, dbz32}, 32'd0);
    checkOutput("rst_busy8", {31'b0, busy8}, 32'd0);
    checkOutput("rst_hi8", {24'b0, hi8}, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] WIDTH=32 directed vectors");
    applyStimulus(0, 2'b00, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0);
    applyStimulus(0, 2'b01, 32'hFFFFFFFD, 32'd7,        32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0);
    applyStimulus(0, 2'b11, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0);
    applyStimulus(0, 2'b10, 32'd100,      32'd7,        32'd2,        32'd14,       1'b0);
    applyStimulus(0, 2'b10, 32'd5,        32'd0,        32'd5,        32'hFFFFFFFF, 1'b1);
    applyStimulus(0, 2'b00, 32'd2,        32'd3,        32'd0,        32'd6,        1'b0);
    applyStimulus(0, 2'b11, 32'hFFFFFFFB, 32'd0,        32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1);
    applyStimulus(0, 2'b11, 32'h80000000, 32'hFFFFFFFF, 32'd0,        32'h80000000, 1'b0);
    applyStimulus(0, 2'b11, 32'd7,        32'hFFFFFFFE, 32'd1,        32'hFFFFFFFD, 1'b0);

    $display("[TB] flush and ignored start");
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd6; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (2) @(negedge clk);
    start32 = 1'b1; a32 = 32'd9; b32 = 32'd9;
    @(negedge clk);
    start32 = 1'b0;
    repeat (6) @(negedge clk);
    flush32 = 1'b1;
    @(negedge clk);
    flush32 = 1'b0;
    checkOutput("flush_busy", {31'b0, busy32}, 32'd0);
    checkOutput("flush_done", {31'b0, done32}, 32'd0);
    checkOutput("flush_hi_kept", hi32, 32'd1);
    checkOutput("flush_lo_kept", lo32, 32'hFFFFFFFD);
    checkOutput("flush_dbz_kept", {31'b0, dbz32}, 32'd0);
    repeat (40) @(negedge clk);
    start32 = 1'b1; flush32 = 1'b1; op32 = 2'b00; a32 = 32'd6; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0; flush32 = 1'b0;
    checkOutput("start_with_flush_busy", {31'b0, busy32}, 32'd0);
    repeat (2) @(negedge clk);
    checkOutput("start_with_flush_idle", {31'b0, busy32}, 32'd0);

    $display("[TB] WIDTH=8 directed vectors");
    applyStimulus(1, 2'b01, 32'h80, 32'h80, 32'h40, 32'h00, 1'b0);
    applyStimulus(1, 2'b00, 32'hFF, 32'hFF, 32'hFE, 32'h01, 1'b0);
    applyStimulus(1, 2'b01, 32'hFD, 32'd7,  32'hFF, 32'hEB, 1'b0);
    applyStimulus(1, 2'b11, 32'hF9, 32'd2,  32'hFF, 32'hFD, 1'b0);
    applyStimulus(1, 2'b10, 32'd100, 32'd7, 32'd2,  32'd14, 1'b0);
    applyStimulus(1, 2'b10, 32'd5,  32'd0,  32'd5,  32'hFF, 1'b1);
    applyStimulus(1, 2'b11, 32'h80, 32'hFF, 32'h00, 32'h80, 1'b0);
    applyStimulus(1, 2'b00, 32'd2,  32'd3,  32'd0,  32'd6,  1'b0);

    $display("[TB] reset mid-run");
    @(negedge clk);
    start32 = 1'b1; op32 = 2'b00; a32 = 32'd6; b32 = 32'd7;
    @(negedge clk);
    start32 = 1'b0;
    repeat (5) @(negedge clk);
    checkOutput("pre_reset_busy", {31'b0, busy32}, 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("midrst_busy32", {31'b0, busy32}, 32'd0);
    checkOutput("midrst_done32", {31'b0, done32}, 32'd0);
    checkOutput("midrst_hi32", hi32, 32'd0);
    checkOutput("midrst_lo32", lo32, 32'd0);
    checkOutput("midrst_dbz32", {31'b0, dbz32}, 32'd0);
    checkOutput("midrst_lo8", {24'b0, lo8}, 32'd0);
    repeat (40) @(negedge clk);

    checkOutput("pending32", 32'(exp_q32.size()), 32'd0);
    checkOutput("pending8", 32'(exp_q8.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/mul_div_unit.md
# mul_div_unit

Parametrised iterative multiply/divide unit for the pipelined MIPS core, executing MULT, MULTU, DIV and DIVU into a HI/LO result pair. It sits beside the EX stage. The hazard logic holds the pipeline while `busy_o` is high and consumes `hi_o`/`lo_o` when `done_o` pulses. It replaces single-cycle ALU arithmetic with a shift-add multiplier and a restoring divider, supporting a width parameter, signed/unsigned modes and a pipeline flush abort.

## Interface
- `WIDTH`, 32: operand width in bits; legal values are even and ≥ 4. `hi_o` and `lo_o` are each `WIDTH` bits.
- `clk_i`  in  1  clock; all state changes on the rising edge.
- `rst_i`  in  1  reset; synchronous, active-high.
- `start_i`  in  1  request an operation; sampled only in IDLE.
- `op_i`  in  2  operation select: 00 MULTU, 01 MULT, 10 DIVU, 11 DIV; sampled with `start_i`.
- `data0_i`  in  WIDTH  multiplicand or dividend (rs).
- `data1_i`  in  WIDTH  multiplier or divisor (rt).
- `flush_i`  in  1  abort any operation in flight (branch/jump flush).
- `busy_o`  out  1  operation in flight; the pipeline stalls on it.
- `done_o`  out  1  one-cycle pulse: `hi_o`/`lo_o` updated this cycle.
- `hi_o`  out  WIDTH  product upper half, or remainder.
- `lo_o`  out  WIDTH  product lower half, or quotient.
- `div_by_zero_o`  out  1  last completed DIV/DIVU had divisor 0; held until the next completion.

## Operation
- **States:** IDLE, RUN, FIX.
- **IDLE:**
  - On `start_i & ~flush_i`, latch `op_i` and operand magnitudes. Signed ops take the two's-complement absolute value; unsigned ops take the raw value.
  - Latch the result signs:
    - MULT product sign = sign0 ^ sign1.
    - DIV quotient sign = sign0 ^ sign1.
    - DIV remainder sign = sign0.
  - Latch the divide-by-zero flag; load the iteration counter with `WIDTH`; go to RUN.
- **RUN:**
  - Performs one iteration per cycle and decrements the counter; when it reaches 0, go to FIX.
  - Multiply: 2·WIDTH-bit accumulator, shift-add one multiplier bit per cycle, LSB first.
  - Divide: restoring divide, one quotient bit per cycle, MSB first. Partial remainder is WIDTH+1 bits wide.
- **FIX:**
  - Apply the latched signs (negate the magnitude where the sign is 1).
  - Write `hi_o` and `lo_o`, pulse `done_o`, update `div_by_zero_o`, return to IDLE.
- **Divisor 0:** result is `lo_o` = all ones, `hi_o` = dividend as presented (unmodified `data0_i`), `div_by_zero_o` = 1. Latency is unchanged.
- **Signed overflow:** DIV of −2^(WIDTH−1) by −1 gives `lo_o` = −2^(WIDTH−1) and `hi_o` = 0. This falls out of the magnitude arithmetic plus negation and is not trapped.
- **`start_i` while busy:** ignored; the pipeline holds the instruction.
- **`flush_i`:**
  - In RUN or FIX, the next edge goes to IDLE with no `done_o`; `hi_o`, `lo_o` and `div_by_zero_o` keep their previous values.
  - In IDLE, `flush_i` blocks acceptance of `start_i`.
- **Priority:** `rst_i` > `flush_i` > `start_i`.

## Timing
- **Reset values:** state IDLE, `busy_o` = 0, `done_o` = 0, `hi_o` = 0, `lo_o` = 0, `div_by_zero_o` = 0, counter = 0.
- **Latency:**
  - Start accepted at edge E0.
  - `busy_o` is high from E0 through the cycle before E0+WIDTH+1.
  - At edge E0+WIDTH+1, `hi_o`/`lo_o` update, `done_o` = 1 for exactly one cycle, and `busy_o` = 0.
  - A new `start_i` can be accepted at edge E0+WIDTH+2, giving one op every WIDTH+2 cycles.
- **Outputs:** all outputs are registered; there are no combinational paths from inputs to outputs.
- **Reset mid-operation:** `rst_i` high at any edge restores all reset values at that edge. No `done_o` is produced for the aborted op.

## Test plan
- **MULTU max × max:** MULTU 0xFFFFFFFF × 0xFFFFFFFF, WIDTH=32 → `hi_o` = 0xFFFFFFFE, `lo_o` = 0x00000001. `done_o` is a single pulse 33 edges after start; `busy_o` is high for exactly 33 cycles.
- **MULT and DIV signs:**
  - MULT −3 × 7 → `hi_o` = 0xFFFFFFFF, `lo_o` = 0xFFFFFFEB.
  - DIV −7 ÷ 2 → `lo_o` = 0xFFFFFFFD, `hi_o` = 0xFFFFFFFF.
  - DIVU 100 ÷ 7 → `lo_o` = 14, `hi_o` = 2.
- **Divide by zero:**
  - DIVU 5 ÷ 0 → `lo_o` = 0xFFFFFFFF, `hi_o` = 5, `div_by_zero_o` = 1.
  - A following MULTU 2 × 3 → `lo_o` = 6, `hi_o` = 0, `div_by_zero_o` = 0.
- **Signed overflow:** DIV 0x80000000 ÷ 0xFFFFFFFF → `lo_o` = 0x80000000, `hi_o` = 0, `div_by_zero_o` = 0.
- **Flush and ignored start:**
  - Start MULTU 6 × 7, pulse `start_i` again 3 cycles later (ignored), then assert `flush_i` 10 cycles after the start.
  - Expected: `busy_o` = 0 at the next edge, no `done_o`, `hi_o`/`lo_o` keep their prior values.
  - A `start_i` with `flush_i` both high in IDLE is not accepted.
- **Reset and parametrisation:**
  - Assert `rst_i` mid-RUN → all outputs return to reset values at that edge.
  - Rerun the multiply/divide cases at WIDTH=8 (e.g. MULT −128 × −128 → `hi_o` = 0x40, `lo_o` = 0x00). Expected latency 9 cycles.
